shared_reg_arbiter: RTL and testbench

Round-robin arbiter and sequencer for one shared WIDTH-bit D flip-flop register written by N_REQ requesters. Each requester raises a request with its data. The arbiter grants one requester at a time for a bounded burst and loads that requester's data into the shared register on every granted cycle. The block sits between the requester logic of a lab design and the shared register, which it contains, so it is the only writer of that register.

---
 rtl/shared_reg_arbiter_if.sv | 26 ++
 rtl/shared_reg_arbiter.sv | 113 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requester logic and the shared-register arbiter.
// The master side raises requests with data; the slave side grants and holds the register.
interface shared_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] dIn;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic                   qValid;
    logic [IDX_W-1:0]       owner;

    modport master (
        output req, dIn,
        input  gnt, busy, q, qValid, owner
    );

    modport slave (
        input  req, dIn,
        output gnt, busy, q, qValid, owner
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that owns one shared register and loads the granted
// requester's data on every granted cycle, for at most MAX_HOLD cycles per grant.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    shared_reg_arbiter_if.slave  bus
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   q_q;
    logic               qValid_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   grantIdx_q;
    logic [HOLD_W-1:0]  holdCnt_q;

    logic [IDX_W-1:0]   winner_d;
    logic               found_d;
    logic [IDX_W-1:0]   scanIdx;
    logic [IDX_W-1:0]   ptr_d;

    // First set request bit scanning upward from the priority pointer, wrapping.
    always_comb begin
        winner_d = '0;
        found_d  = 1'b0;
        scanIdx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scanIdx = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!found_d && bus.req[scanIdx]) begin
                winner_d = scanIdx;
                found_d  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = IDX_W'((int'(grantIdx_q) + 1) % N_REQ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            q_q        <= '0;
            qValid_q   <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
            grantIdx_q <= '0;
            holdCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q    <= GRANT;
                        gnt_q      <= N_REQ'(1) << winner_d;
                        busy_q     <= 1'b1;
                        grantIdx_q <= winner_d;
                        holdCnt_q  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    // A dropped request releases without loading; otherwise load,
                    // and release once the burst has used its full allowance.
                    if (bus.req[grantIdx_q]) begin
                        q_q      <= bus.dIn[grantIdx_q*WIDTH +: WIDTH];
                        owner_q  <= grantIdx_q;
                        qValid_q <= 1'b1;
                        if (holdCnt_q < HOLD_W'(MAX_HOLD)) begin
                            holdCnt_q <= holdCnt_q + HOLD_W'(1);
                        end else begin
                            state_q   <= IDLE;
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            ptr_q     <= ptr_d;
                            holdCnt_q <= '0;
                        end
                    end else begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= ptr_d;
                        holdCnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.q      = q_q;
    assign bus.qValid = qValid_q;
    assign bus.owner  = owner_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, short write, hold limit,
// round-robin rotation, wrap-around arbitration and asynchronous reset mid-burst.
module tb_shared_reg_arbiter;
    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rstN;
    int   checkCount;
    int   errorCount;

    shared_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    shared_reg_arbiter #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] reqVal,
                                 input logic [7:0] s3, input logic [7:0] s2,
                                 input logic [7:0] s1, input logic [7:0] s0);
        bus.req = reqVal;
        bus.dIn = {s3, s2, s1, s0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] gnt, input logic busy,
                            input logic [7:0] q, input logic qValid, input logic [1:0] owner);
        checkOutput({tag, ".gnt"},    32'(bus.gnt),    32'(gnt));
        checkOutput({tag, ".busy"},   32'(bus.busy),   32'(busy));
        checkOutput({tag, ".q"},      32'(bus.q),      32'(q));
        checkOutput({tag, ".qValid"}, 32'(bus.qValid), 32'(qValid));
        checkOutput({tag, ".owner"},  32'(bus.owner),  32'(owner));
    endtask

    initial begin
        logic [3:0] expGnt;
        logic [7:0] expQ;
        checkCount = 0;
        errorCount = 0;
        rstN = 1'b0;
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset held three cycles, then idle for five.
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        checkAll("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll("resetIdle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        end

        // Single short write from requester 1.
        applyStimulus(4'b0010, 8'h00, 8'h00, 8'hA5, 8'h00);
        tick();
        checkAll("short.grant", 4'b0010, 1'b1, 8'h00, 1'b0, 2'd0);
        tick();
        checkAll("short.load", 4'b0010, 1'b1, 8'hA5, 1'b1, 2'd1);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        checkAll("short.release", 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd1);

        // Hold limit: requester 0 alone, data incrementing each cycle.
        applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'h10);
        tick();
        checkAll("hold.grant", 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'(8'h10 + i));
            tick();
            expGnt = (i == 3) ? 4'b0000 : 4'b0001;
            checkAll("hold.load", expGnt, (i != 3), 8'(8'h10 + i), 1'b1, 2'd0);
        end
        applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'h14);
        tick();
        checkAll("hold.regrant", 4'b0001, 1'b1, 8'h13, 1'b1, 2'd0);
        tick();
        checkAll("hold.load5", 4'b0001, 1'b1, 8'h14, 1'b1, 2'd0);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h14);
        tick();
        checkAll("hold.release", 4'b0000, 1'b0, 8'h14, 1'b1, 2'd0);

        // Pointer back to 0 before rotation: reset pulse between edges.
        #2 rstN = 1'b0;
        #1 rstN = 1'b1;
        checkAll("midReset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);

        // Round-robin rotation with all requesters held high.
        applyStimulus(4'b1111, 8'hC3, 8'hC2, 8'hC1, 8'hC0);
        for (int g = 0; g < 5; g++) begin
            tick();
            expGnt = 4'b0001 << (g % 4);
            checkOutput("rr.grant", 32'(bus.gnt), 32'(expGnt));
            for (int l = 1; l <= MAX_HOLD; l++) begin
                tick();
                expQ = 8'(8'hC0 + (g % 4));
                checkOutput("rr.owner", 32'(bus.owner), 32'(g % 4));
                checkOutput("rr.q", 32'(bus.q), 32'(expQ));
                checkOutput("rr.gnt", 32'(bus.gnt), (l == MAX_HOLD) ? 32'd0 : 32'(expGnt));
            end
        end
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("rr.idle", 32'(bus.gnt), 32'd0);

        // Requester 2 finishes while 0 and 2 both request; pointer wraps to 0.
        applyStimulus(4'b0100, 8'h00, 8'h22, 8'h00, 8'h20);
        tick();
        checkOutput("wrap.grant2", 32'(bus.gnt), 32'b0100);
        applyStimulus(4'b0101, 8'h00, 8'h22, 8'h00, 8'h20);
        repeat (MAX_HOLD) tick();
        checkAll("wrap.release2", 4'b0000, 1'b0, 8'h22, 1'b1, 2'd2);
        tick();
        checkOutput("wrap.grant0", 32'(bus.gnt), 32'b0001);
        tick();
        checkAll("wrap.load0", 4'b0001, 1'b1, 8'h20, 1'b1, 2'd0);
        applyStimulus(4'b0100, 8'h00, 8'h22, 8'h00, 8'h20);
        tick();
        checkAll("wrap.release0", 4'b0000, 1'b0, 8'h20, 1'b1, 2'd0);
        tick();
        checkOutput("wrap.regrant2", 32'(bus.gnt), 32'b0100);

        // Asynchronous reset in the middle of a burst.
        applyStimulus(4'b0100, 8'h00, 8'h5A, 8'h00, 8'h00);
        tick();
        checkAll("async.preload", 4'b0100, 1'b1, 8'h5A, 1'b1, 2'd2);
        #2 rstN = 1'b0;
        #1;
        checkAll("async.inReset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        rstN = 1'b1;
        tick();
        checkAll("async.grant2", 4'b0100, 1'b1, 8'h00, 1'b0, 2'd0);
        tick();
        checkAll("async.load2", 4'b0100, 1'b1, 8'h5A, 1'b1, 2'd2);

        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
